capture_write_ctrl: RTL and testbench

// Sample-buffer write controller for the logic capture peripheral. Sits between the sampler/trigger

---
 rtl/capture_write_ctrl.sv | 76 +++++++
 tb/tb_capture_write_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/capture_write_ctrl.sv
// capture_write_ctrl: circular sample-RAM write controller driven by the analyzer FSM state; optional PRETRIG_ARM_EN gates triggers on pre-trigger fill
module capture_write_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int PAGE_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              idle,
  input  logic              pre_trigger,
  input  logic              post_trigger,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              trigger_hit,
  input  logic [ADDR_W-1:0] post_count,
  input  logic [ADDR_W-1:0] pre_depth,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              saw_trigger,
  output logic              page_full,
  output logic              complete,
  output logic [ADDR_W-1:0] trigger_addr,
  output logic              wrapped
);
  logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_e, wr_addr_q, wr_addr_d, trig_q, trig_d, post_left_q, post_left_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W:0]   fill_q, fill_d, fill_e;
  logic wr_en_q, wr_en_d, complete_q, complete_d, wrapped_q, wrapped_d, wrapped_e;
  logic done_q, done_d, done_e, pre_q, arm, accept, armed, finish;
`ifdef PRETRIG_ARM_EN
  assign armed = fill_e >= {1'b0, pre_depth};
`else
  logic unused_pre_depth;
  assign unused_pre_depth = ^pre_depth;
  assign armed = 1'b1;
`endif
  assign saw_trigger  = pre_trigger & trigger_hit & armed;
  assign page_full    = ptr_q[PAGE_W-1:0] == '0;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign complete     = complete_q;
  assign trigger_addr = trig_q;
  assign wrapped      = wrapped_q;
  // Arm restarts the buffer in the same cycle; an exhausted post count blocks writes so post_count=0 writes nothing
  always_comb begin
    arm         = pre_trigger & ~pre_q;
    ptr_e       = arm ? '0 : ptr_q;
    fill_e      = arm ? '0 : fill_q;
    done_e      = arm ? 1'b0 : done_q;
    wrapped_e   = arm ? 1'b0 : wrapped_q;
    accept      = sample_valid & ~done_e & (pre_trigger | (post_trigger & post_left_q != '0));
    finish      = post_trigger & ~done_e & (post_left_q == '0 | (accept & post_left_q == ADDR_W'(1)));
    ptr_d       = accept ? ptr_e + ADDR_W'(1) : ptr_e;
    wrapped_d   = wrapped_e | (accept & (&ptr_e));
    fill_d      = fill_e + {{ADDR_W{1'b0}}, accept & ~fill_e[ADDR_W]};
    wr_en_d     = accept;
    wr_addr_d   = accept ? ptr_e : wr_addr_q;
    wr_data_d   = accept ? sample_in : wr_data_q;
    complete_d  = finish;
    done_d      = idle ? 1'b0 : (done_e | finish);
    post_left_d = idle ? '0 : saw_trigger ? post_count : (accept & post_trigger) ? post_left_q - ADDR_W'(1) : post_left_q;
    trig_d      = saw_trigger ? ptr_e + {{(ADDR_W-1){1'b0}}, accept} : trig_q;
  end
  // State registers; reset drops any pending write
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0; wr_addr_q <= '0; trig_q <= '0; post_left_q <= '0; wr_data_q <= '0; fill_q <= '0;
      wr_en_q <= 1'b0; complete_q <= 1'b0; wrapped_q <= 1'b0; done_q <= 1'b0; pre_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d; wr_addr_q <= wr_addr_d; trig_q <= trig_d; post_left_q <= post_left_d; wr_data_q <= wr_data_d; fill_q <= fill_d;
      wr_en_q <= wr_en_d; complete_q <= complete_d; wrapped_q <= wrapped_d; done_q <= done_d; pre_q <= pre_trigger;
    end
  end
endmodule

// File: tb/tb_capture_write_ctrl.sv
// tb_capture_write_ctrl: directed checks of capture_write_ctrl with a 16-entry buffer and 16-sample pages
module tb_capture_write_ctrl;
  logic clk = 1'b0, reset = 1'b1, idle = 1'b0, pre_trigger = 1'b0, post_trigger = 1'b0, sample_valid = 1'b0, trigger_hit = 1'b0;
  logic [7:0] sample_in = '0;
  logic [3:0] post_count = '0, pre_depth = '0;
  logic wr_en, saw_trigger, page_full, complete, wrapped;
  logic [3:0] wr_addr, trigger_addr;
  logic [7:0] wr_data;
  int n_checks = 0, n_fail = 0;

  capture_write_ctrl #(.DATA_W(8), .ADDR_W(4), .PAGE_W(4)) dut (
    .clk(clk), .reset(reset), .idle(idle), .pre_trigger(pre_trigger), .post_trigger(post_trigger),
    .sample_valid(sample_valid), .sample_in(sample_in), .trigger_hit(trigger_hit), .post_count(post_count),
    .pre_depth(pre_depth), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .saw_trigger(saw_trigger),
    .page_full(page_full), .complete(complete), .trigger_addr(trigger_addr), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  task automatic drv(input logic id, input logic pr, input logic po, input logic sv, input logic [7:0] d, input logic th);
    idle = id; pre_trigger = pr; post_trigger = po; sample_valid = sv; sample_in = d; trigger_hit = th;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; drv(0, 0, 1, 1, 8'h55, 0);
    tick(); tick();
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %0b expected 0", wr_en); end
    n_checks++; if (wr_addr !== 4'd0) begin n_fail++; $display("FAIL reset_wr_addr got %0d expected 0", wr_addr); end
    n_checks++; if (wr_data !== 8'd0) begin n_fail++; $display("FAIL reset_wr_data got %0h expected 0", wr_data); end
    n_checks++; if (complete !== 1'b0) begin n_fail++; $display("FAIL reset_complete got %0b expected 0", complete); end
    n_checks++; if (page_full !== 1'b1) begin n_fail++; $display("FAIL reset_page_full got %0b expected 1", page_full); end
    n_checks++; if (wrapped !== 1'b0 || trigger_addr !== 4'd0) begin n_fail++; $display("FAIL reset_wrap_trig got %0b/%0d expected 0/0", wrapped, trigger_addr); end
    reset = 1'b0; drv(1, 0, 0, 0, 0, 0); tick();
  endtask

  task automatic test_capture();
    post_count = 4'd4; pre_depth = 4'd0;
    for (int i = 0; i < 10; i++) begin
      drv(0, 1, 0, 1, 8'hA0 + 8'(i), 0); tick();
      n_checks++; if (wr_en !== 1'b1 || wr_addr !== 4'(i) || wr_data !== 8'hA0 + 8'(i)) begin n_fail++; $display("FAIL cap_pre%0d got en=%0b addr=%0d data=%0h expected 1/%0d/%0h", i, wr_en, wr_addr, wr_data, i, 8'hA0 + 8'(i)); end
    end
    drv(0, 1, 0, 0, 0, 1); #1;
    n_checks++; if (saw_trigger !== 1'b1) begin n_fail++; $display("FAIL cap_saw_trigger got %0b expected 1", saw_trigger); end
    tick();
    n_checks++; if (wr_en !== 1'b0 || trigger_addr !== 4'd10) begin n_fail++; $display("FAIL cap_trig got en=%0b taddr=%0d expected 0/10", wr_en, trigger_addr); end
    for (int i = 0; i < 4; i++) begin
      drv(0, 0, 1, 1, 8'hB0 + 8'(i), 0); tick();
      n_checks++; if (wr_en !== 1'b1 || wr_addr !== 4'(10 + i) || complete !== (i == 3)) begin n_fail++; $display("FAIL cap_post%0d got en=%0b addr=%0d cmp=%0b expected 1/%0d/%0b", i, wr_en, wr_addr, complete, 10 + i, i == 3); end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (wr_en !== 1'b0 || complete !== 1'b0) begin n_fail++; $display("FAIL cap_after%0d got en=%0b cmp=%0b expected 0/0", i, wr_en, complete); end
    end
  endtask

  task automatic test_idle_drop();
    drv(1, 0, 0, 1, 8'h77, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (wr_en !== 1'b0 || page_full !== 1'b0 || trigger_addr !== 4'd10) begin n_fail++; $display("FAIL idle_drop%0d got en=%0b pf=%0b taddr=%0d expected 0/0/10", i, wr_en, page_full, trigger_addr); end
    end
  endtask

  task automatic test_wrap_zero_post();
    post_count = 4'd0;
    for (int i = 0; i < 20; i++) begin
      drv(0, 1, 0, 1, 8'(i), 0); tick();
      n_checks++; if (wr_en !== 1'b1 || wr_addr !== 4'(i % 16) || wrapped !== (i >= 15)) begin n_fail++; $display("FAIL wrap%0d got en=%0b addr=%0d wr=%0b expected 1/%0d/%0b", i, wr_en, wr_addr, wrapped, i % 16, i >= 15); end
    end
    drv(0, 1, 0, 0, 0, 1); tick();
    n_checks++; if (trigger_addr !== 4'd4 || wrapped !== 1'b1) begin n_fail++; $display("FAIL wrap_trig got taddr=%0d wr=%0b expected 4/1", trigger_addr, wrapped); end
    drv(0, 0, 1, 1, 8'hEE, 0); tick();
    n_checks++; if (complete !== 1'b1 || wr_en !== 1'b0) begin n_fail++; $display("FAIL zero_post_cmp got cmp=%0b en=%0b expected 1/0", complete, wr_en); end
    tick();
    n_checks++; if (complete !== 1'b0 || wr_en !== 1'b0) begin n_fail++; $display("FAIL zero_post_after got cmp=%0b en=%0b expected 0/0", complete, wr_en); end
    drv(1, 0, 0, 0, 0, 0); tick();
    n_checks++; if (wrapped !== 1'b1 || trigger_addr !== 4'd4) begin n_fail++; $display("FAIL idle_hold got wr=%0b taddr=%0d expected 1/4", wrapped, trigger_addr); end
  endtask

  task automatic test_page_full();
    for (int k = 0; k < 17; k++) begin
      drv(0, 1, 0, 1, 8'(k), 0); tick();
      n_checks++; if (wr_en !== 1'b1 || page_full !== ((k + 1) % 16 == 0)) begin n_fail++; $display("FAIL page%0d got en=%0b pf=%0b expected 1/%0b", k, wr_en, page_full, (k + 1) % 16 == 0); end
      drv(0, 1, 0, 0, 0, 0);
      for (int g = 0; g < 2; g++) begin
        tick();
        n_checks++; if (wr_en !== 1'b0 || page_full !== ((k + 1) % 16 == 0)) begin n_fail++; $display("FAIL page_gap%0d_%0d got en=%0b pf=%0b expected 0/%0b", k, g, wr_en, page_full, (k + 1) % 16 == 0); end
      end
    end
    drv(1, 0, 0, 0, 0, 0); tick();
  endtask

  task automatic test_prearm();
    logic exp_early;
`ifdef PRETRIG_ARM_EN
    exp_early = 1'b0;
`else
    exp_early = 1'b1;
`endif
    pre_depth = 4'd8;
    for (int i = 0; i < 3; i++) begin drv(0, 1, 0, 1, 8'(i), 0); tick(); end
    drv(0, 1, 0, 0, 0, 1); #1;
    n_checks++; if (saw_trigger !== exp_early) begin n_fail++; $display("FAIL prearm_fill3 got %0b expected %0b", saw_trigger, exp_early); end
    tick();
    for (int i = 0; i < 6; i++) begin drv(0, 1, 0, 1, 8'(i), 0); tick(); end
    drv(0, 1, 0, 0, 0, 1); #1;
    n_checks++; if (saw_trigger !== 1'b1) begin n_fail++; $display("FAIL prearm_fill9 got %0b expected 1", saw_trigger); end
    tick();
    n_checks++; if (trigger_addr !== 4'd9) begin n_fail++; $display("FAIL prearm_taddr got %0d expected 9", trigger_addr); end
    pre_depth = 4'd0; drv(1, 0, 0, 0, 0, 0); tick();
  endtask

  task automatic test_reset_mid();
    post_count = 4'd4;
    for (int i = 0; i < 2; i++) begin drv(0, 1, 0, 1, 8'(i), 0); tick(); end
    drv(0, 1, 0, 0, 0, 1); tick();
    drv(0, 0, 1, 1, 8'h33, 0); tick();
    n_checks++; if (wr_en !== 1'b1 || wr_addr !== 4'd2) begin n_fail++; $display("FAIL mid_post got en=%0b addr=%0d expected 1/2", wr_en, wr_addr); end
    reset = 1'b1; tick();
    n_checks++; if (wr_en !== 1'b0 || complete !== 1'b0 || page_full !== 1'b1 || wr_addr !== 4'd0 || trigger_addr !== 4'd0) begin n_fail++; $display("FAIL mid_reset got en=%0b cmp=%0b pf=%0b addr=%0d taddr=%0d expected 0/0/1/0/0", wr_en, complete, page_full, wr_addr, trigger_addr); end
    reset = 1'b0; drv(1, 0, 0, 0, 0, 0); tick();
    drv(0, 1, 0, 1, 8'h44, 0); tick();
    n_checks++; if (wr_en !== 1'b1 || wr_addr !== 4'd0 || wr_data !== 8'h44) begin n_fail++; $display("FAIL after_reset got en=%0b addr=%0d data=%0h expected 1/0/44", wr_en, wr_addr, wr_data); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_idle_drop();
    test_wrap_zero_post();
    test_page_full();
    test_prearm();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
